// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants, drawer FSM states and framebuffer
// address helper used by both the sprite drawer and the LCD scanner.
package chip8_pkg;

    localparam int SCREEN_W     = 64;
    localparam int SCREEN_H     = 32;
    localparam int FB_ROW_BYTES = 32;
    localparam int FB_ADDR_W    = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RDL,
        WRL,
        RDR,
        WRR,
        CLR,
        DONE
    } state_t;

    function automatic logic [FB_ADDR_W-1:0] fb_byte_addr(
        input int row,
        input int col,
        input int stride = FB_ROW_BYTES
    );
        return FB_ADDR_W'(row * stride + col);
    endfunction

endpackage

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DRW/CLS engine: XOR-blits sprites into the display RAM by
// read-modify-write and reports the VF collision flag.
module chip8_sprite_drawer #(
    parameter int FB_ROW_BYTES = chip8_pkg::FB_ROW_BYTES,
    parameter int SCREEN_W     = chip8_pkg::SCREEN_W,
    parameter int SCREEN_H     = chip8_pkg::SCREEN_H
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_draw,
    input  logic                            start_clear,
    input  logic [7:0]                      vx,
    input  logic [7:0]                      vy,
    input  logic [3:0]                      n,
    input  logic [11:0]                     i_addr,
    output logic                            busy,
    output logic                            done,
    output logic                            collision,
    output logic [11:0]                     spr_addr,
    input  logic [7:0]                      spr_data,
    output logic [chip8_pkg::FB_ADDR_W-1:0] fb_addr,
    output logic                            fb_we,
    output logic [7:0]                      fb_wdata,
    input  logic [7:0]                      fb_rdata
);
    import chip8_pkg::*;

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int BW = XW - 3;
    localparam int CW = YW + BW;

    state_t          state_q;
    state_t          state_d;
    logic [XW-1:0]   vx_q;
    logic [YW-1:0]   vy_q;
    logic [3:0]      n_q;
    logic [3:0]      row_q;
    logic [11:0]     i_q;
    logic [7:0]      spr_q;
    logic            coll_q;
    logic [CW-1:0]   clr_q;

    logic [YW-1:0]   y;
    logic [2:0]      off;
    logic [BW-1:0]   bl;
    logic [BW-1:0]   br;
    logic [15:0]     sh;
    logic            accept;
    logic            last_row;
    logic            unused_bits;

    assign y        = vy_q + YW'(row_q);
    assign off      = vx_q[2:0];
    assign bl       = vx_q[XW-1:3];
    assign br       = bl + BW'(1);
    // upper byte is the left-byte mask, lower byte the spill into the right byte
    assign sh       = {spr_q, 8'h00} >> off;
    assign accept   = (state_q == IDLE) && (start_draw || start_clear);
    assign last_row = (row_q == n_q - 4'd1);

    assign unused_bits = ^{vx[7:XW], vy[7:YW]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_clear) begin
                    state_d = CLR;
                end else if (start_draw) begin
                    state_d = (n == 4'd0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = RDL;
            RDL:   state_d = WRL;
            WRL: begin
                if (off != 3'd0) begin
                    state_d = RDR;
                end else begin
                    state_d = last_row ? DONE : FETCH;
                end
            end
            RDR:   state_d = WRR;
            WRR:   state_d = last_row ? DONE : FETCH;
            CLR:   state_d = (&clr_q) ? DONE : CLR;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vx_q   <= '0;
            vy_q   <= '0;
            n_q    <= '0;
            row_q  <= '0;
            i_q    <= '0;
            spr_q  <= '0;
            coll_q <= 1'b0;
            clr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        vx_q   <= vx[XW-1:0];
                        vy_q   <= vy[YW-1:0];
                        n_q    <= n;
                        i_q    <= i_addr;
                        row_q  <= '0;
                        clr_q  <= '0;
                        coll_q <= 1'b0;
                    end
                end
                RDL: spr_q <= spr_data;
                WRL: begin
                    coll_q <= coll_q | (|(fb_rdata & sh[15:8]));
                    if (off == 3'd0) begin
                        row_q <= row_q + 4'd1;
                    end
                end
                WRR: begin
                    coll_q <= coll_q | (|(fb_rdata & sh[7:0]));
                    row_q  <= row_q + 4'd1;
                end
                CLR: clr_q <= clr_q + CW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        collision = coll_q;
        spr_addr  = '0;
        fb_addr   = '0;
        fb_we     = 1'b0;
        fb_wdata  = '0;
        unique case (1'b1)
            (state_q == FETCH): begin
                spr_addr = i_q + 12'(row_q);
            end
            (state_q == RDL), (state_q == WRL): begin
                fb_addr = fb_byte_addr(int'(y), int'(bl), FB_ROW_BYTES);
                fb_we   = (state_q == WRL);
                if (fb_we) begin
                    fb_wdata = fb_rdata ^ sh[15:8];
                end
            end
            (state_q == RDR), (state_q == WRR): begin
                fb_addr = fb_byte_addr(int'(y), int'(br), FB_ROW_BYTES);
                fb_we   = (state_q == WRR);
                if (fb_we) begin
                    fb_wdata = fb_rdata ^ sh[7:0];
                end
            end
            (state_q == CLR): begin
                fb_addr = fb_byte_addr(int'(clr_q[CW-1:BW]),
                                       int'(clr_q[BW-1:0]),
                                       FB_ROW_BYTES);
                fb_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/chip8_sprite_drawer.md
# chip8_sprite_drawer

Writer side of the CHIP-8 framebuffer: executes DRW (XOR-blit of an n-byte sprite at (Vx,Vy), collision flag VF) and CLS (clear) by read-modify-write into the 1024-byte display RAM that the ST7920 LCD scanner reads. Sits between the CPU core (command pulse, busy/done handshake) and the framebuffer RAM's second port. It also reads sprite bytes from main memory through a dedicated read port.

## Interface
Parameters:
- FB_ROW_BYTES, 32: framebuffer bytes per row; address = row*FB_ROW_BYTES + byte.
- SCREEN_W, 64: CHIP-8 width in pixels; only bytes 0..7 of each row are written.
- SCREEN_H, 32: CHIP-8 height in rows.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start_draw  in  1  one-cycle DRW request; sampled only in IDLE.
- start_clear  in  1  one-cycle CLS request; sampled only in IDLE; wins over start_draw.
- vx  in  8  sprite X (Vx), taken mod 64.
- vy  in  8  sprite Y (Vy), taken mod 32.
- n  in  4  sprite height in bytes.
- i_addr  in  12  sprite base address (I).
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at completion.
- collision  out  1  VF result, valid and held from done until next acceptance.
- spr_addr  out  12  sprite memory address; spr_data valid 1 cycle later.
- spr_data  in  8  sprite byte.
- fb_addr  out  10  framebuffer address.
- fb_we  out  1  framebuffer write strobe.
- fb_wdata  out  8  write data.
- fb_rdata  in  8  read data, valid 1 cycle after fb_addr with fb_we=0.

## Operation
- Pixel (x,y): byte y*32 + x>>3, bit 7-(x&7) (MSB leftmost).
- Inputs vx, vy, n, i_addr are latched on acceptance; later changes are ignored.
- DRW per row r (0..n-1): row = (vy+r) mod 32; off = vx&7; left byte bl = (vx>>3)&7; right byte br = (bl+1)&7 (horizontal wrap); sprite address = (i_addr+r) mod 4096.
- FSM states: IDLE, FETCH, RDL, WRL, RDR, WRR, CLR, DONE.
  - FETCH drives spr_addr.
  - RDL latches spr_data and drives fb_addr = left address.
  - WRL writes fb_rdata ^ (spr>>off) and ORs (fb_rdata & (spr>>off)) != 0 into collision.
  - If off==0, WRL goes to the next row's FETCH; otherwise it goes to RDR.
  - RDR/WRR do the same for the right byte with mask (spr<<(8-off))[7:0].
  - After the last row, go to DONE.
- n==0: no memory access; IDLE→DONE; collision=0.
- CLS: CLR writes 0x00 to row*32+b for row 0..31, b 0..7 (256 writes, row-major, one per cycle), then DONE. Bytes 8..31 of each row are never touched.
- Acceptance clears the collision accumulator.
- start_* while busy: ignored; no queueing.
- Reset, including mid-operation: next state IDLE; busy=0, done=0, collision=0, fb_we=0, fb_addr=0, fb_wdata=0, spr_addr=0. Partially written framebuffer content is not restored.

## Timing
- Acceptance edge: IDLE→FETCH (draw, n>0), CLR (clear), or DONE (n==0).
- Row cost: 3 cycles if off==0, 5 otherwise.
- DRW latency, acceptance edge to done: 3n+1 or 5n+1 cycles. CLS: 257 cycles. n==0: 1 cycle.
- done is high for exactly one cycle, in DONE; DONE→IDLE. A new start is accepted the cycle after done.
- fb_we is asserted only in WRL, WRR and CLR; at most one write per cycle. No read and write in the same cycle.
- Outputs are registered/state-decoded; there is no combinational path from fb_rdata to fb_addr.

## Structure
- Shared package chip8_pkg: SCREEN_W, SCREEN_H, FB_ROW_BYTES, FB_ADDR_W=10, state enum, and fb_byte_addr(row,byte) function (also used by the LCD scanner's address math).
- Single module with no sub-module; the shift/XOR datapath is inline.

## Test plan
- CLS on a framebuffer preset to 0xFF: 256 writes of 0x00 to bytes 0..7 of every row; byte 8 of row 0 stays 0xFF; done at cycle 257.
- DRW vx=0, vy=0, n=5, sprite "0" (F0 90 90 90 F0) on an empty framebuffer: addresses 0,32,64,96,128 receive F0,90,90,90,F0; collision=0; latency 16.
- Repeat the same DRW: bytes return to 0x00; collision=1.
- DRW vx=60, vy=30, n=3, sprite FF FF FF: rows 30, 31, 0 get byte 7=0x0F and byte 0=0xF0 (wrap in both axes); latency 16.
- start_draw and start_clear together: clear executes; a start_draw pulsed mid-clear is ignored; n==0 gives done 1 cycle after acceptance with no fb_we.
- Reset asserted in WRR: next cycle IDLE, fb_we=0, busy=0; a new DRW afterwards completes normally.
